// File: rtl/plab5_mcore_net_msg_to_mem_req_q_pkg.sv
// Shared field widths and type codes for the bank-side network-to-memory-request adapter.
package plab5_mcore_net_msg_to_mem_req_q_pkg;

   localparam logic [2:0] MEM_REQ_TYPE_READ  = 3'd0;
   localparam logic [2:0] MEM_REQ_TYPE_WRITE = 3'd1;

   function automatic int unsigned mem_len_nbits(input int unsigned md);
      return $clog2(md / 8);
   endfunction

   // Memory request minus its data field; also the payload width less the domain bit.
   function automatic int unsigned mem_req_ctrl_nbits(input int unsigned mo, input int unsigned ma,
                                                      input int unsigned md);
      return 3 + mo + ma + mem_len_nbits(md);
   endfunction

endpackage

// File: rtl/plab5_mcore_net_msg_to_mem_req_q_unpack.sv
// Combinational splitter: pulls dest/src/req_domain out of a network control word and
// repacks payload + data into a memory request whose opaque top bits carry the source core.
module plab5_mcore_NetMsgUnpack
   import plab5_mcore_net_msg_to_mem_req_q_pkg::*;
#(
   parameter int unsigned p_mem_opaque_nbits  = 8,
   parameter int unsigned p_mem_addr_nbits    = 32,
   parameter int unsigned p_mem_data_nbits    = 32,
   parameter int unsigned p_net_opaque_nbits  = 4,
   parameter int unsigned p_net_srcdest_nbits = 3,
   localparam int unsigned MO  = p_mem_opaque_nbits,
   localparam int unsigned NS  = p_net_srcdest_nbits,
   localparam int unsigned NPC = mem_req_ctrl_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
   localparam int unsigned REQ = NPC + p_mem_data_nbits,
   localparam int unsigned CNB = NPC + 1 + p_net_opaque_nbits + 2 * p_net_srcdest_nbits,
   localparam int unsigned ALN = p_mem_addr_nbits + mem_len_nbits(p_mem_data_nbits)
)(
   input  logic [CNB-1:0]              msg_control,
   input  logic [p_mem_data_nbits-1:0] msg_data,
   output logic [NS-1:0]               dest,
   output logic [NS-1:0]               src,
   output logic                        req_domain,
   output logic [REQ-1:0]              req
);

   logic [2:0]    req_type;
   logic [MO-1:0] pay_opaque;
   logic          unused_bits;

   assign dest       = msg_control[CNB-1 -: NS];
   assign src        = msg_control[CNB-NS-1 -: NS];
   assign req_domain = msg_control[NPC];
   assign req_type   = msg_control[NPC-1 -: 3];
   assign pay_opaque = msg_control[NPC-4 -: MO];

   // Source id overwrites the top opaque bits so the response can be routed back to the core.
   assign req = {req_type, src, pay_opaque[MO-NS-1:0], msg_control[ALN-1:0], msg_data};

   assign unused_bits = ^{msg_control[CNB-2*NS-1 : NPC+1], pay_opaque[MO-1 -: NS]};

endmodule

// File: rtl/plab5_mcore_net_msg_to_mem_req_q.sv
// Terminates memory-request network messages at one bank: drops misrouted messages (counted),
// repacks the rest and buffers them in a 2-entry queue; 1-cycle latency, no bypass.
module plab5_mcore_net_msg_to_mem_req_q
   import plab5_mcore_net_msg_to_mem_req_q_pkg::*;
#(
   parameter int unsigned p_bank_id           = 0,
   parameter int unsigned p_mem_opaque_nbits  = 8,
   parameter int unsigned p_mem_addr_nbits    = 32,
   parameter int unsigned p_mem_data_nbits    = 32,
   parameter int unsigned p_net_opaque_nbits  = 4,
   parameter int unsigned p_net_srcdest_nbits = 3,
   localparam int unsigned NS  = p_net_srcdest_nbits,
   localparam int unsigned NPC = mem_req_ctrl_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
   localparam int unsigned REQ = NPC + p_mem_data_nbits,
   localparam int unsigned CNB = NPC + 1 + p_net_opaque_nbits + 2 * p_net_srcdest_nbits
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        domain,
   input  logic                        in_val,
   output logic                        in_rdy,
   input  logic [CNB-1:0]              in_msg_control,
   input  logic [p_mem_data_nbits-1:0] in_msg_data,
   output logic                        out_val,
   input  logic                        out_rdy,
   output logic [REQ-1:0]              out_msg,
   output logic                        out_req_domain,
   output logic [7:0]                  drop_count
);

   logic [NS-1:0]  dest;
   logic [NS-1:0]  unused_src;
   logic           req_domain;
   logic [REQ-1:0] req;
   logic           unused_domain;

   plab5_mcore_NetMsgUnpack #(
      .p_mem_opaque_nbits  (p_mem_opaque_nbits),
      .p_mem_addr_nbits    (p_mem_addr_nbits),
      .p_mem_data_nbits    (p_mem_data_nbits),
      .p_net_opaque_nbits  (p_net_opaque_nbits),
      .p_net_srcdest_nbits (p_net_srcdest_nbits)
   ) u_unpack (
      .msg_control (in_msg_control),
      .msg_data    (in_msg_data),
      .dest        (dest),
      .src         (unused_src),
      .req_domain  (req_domain),
      .req         (req)
   );

   assign unused_domain = domain;

   // Storage: data entries are Domain-domain, pointers/count are Control-domain.
   logic [REQ-1:0] entry_msg_q [2];
   logic           entry_dom_q [2];
   logic [1:0]     count_q, count_d;
   logic           enq_ptr_q, enq_ptr_d;
   logic           deq_ptr_q, deq_ptr_d;
   logic [7:0]     drop_count_q, drop_count_d;
   logic           accept, enq, drop, deq;

   assign in_rdy         = (count_q != 2'd2) || out_rdy;
   assign out_val        = (count_q != 2'd0);
   assign out_msg        = entry_msg_q[deq_ptr_q];
   assign out_req_domain = entry_dom_q[deq_ptr_q];
   assign drop_count     = drop_count_q;

   always_comb begin
      accept       = in_val && in_rdy;
      enq          = accept && (dest == NS'(p_bank_id));
      drop         = accept && (dest != NS'(p_bank_id));
      deq          = out_val && out_rdy;
      count_d      = count_q;
      enq_ptr_d    = enq_ptr_q ^ enq;
      deq_ptr_d    = deq_ptr_q ^ deq;
      drop_count_d = drop_count_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (drop && (drop_count_q != 8'hFF))
         drop_count_d = drop_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q      <= 2'd0;
         enq_ptr_q    <= 1'b0;
         deq_ptr_q    <= 1'b0;
         drop_count_q <= 8'd0;
      end else begin
         count_q      <= count_d;
         enq_ptr_q    <= enq_ptr_d;
         deq_ptr_q    <= deq_ptr_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         entry_msg_q[enq_ptr_q] <= req;
         entry_dom_q[enq_ptr_q] <= req_domain;
      end
   end

endmodule

// File: tb/tb_plab5_mcore_net_msg_to_mem_req_q.sv
// Directed bench for the bank-side network-to-memory-request adapter.
module tb_plab5_mcore_net_msg_to_mem_req_q;

   logic        clk = 1'b0;
   logic        reset;
   logic        domain;
   logic        in_val;
   logic        in_rdy;
   logic [55:0] ctrl;
   logic [31:0] data;
   logic        out_val;
   logic        out_rdy;
   logic [76:0] out_msg;
   logic        out_req_domain;
   logic [7:0]  drop_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   plab5_mcore_net_msg_to_mem_req_q dut (
      .clk            (clk),
      .reset          (reset),
      .domain         (domain),
      .in_val         (in_val),
      .in_rdy         (in_rdy),
      .in_msg_control (ctrl),
      .in_msg_data    (data),
      .out_val        (out_val),
      .out_rdy        (out_rdy),
      .out_msg        (out_msg),
      .out_req_domain (out_req_domain),
      .drop_count     (drop_count)
   );

   // Control word {dest, src, net_opaque, req_domain, type, opaque, addr, len}; net opaque fixed at 0xA.
   function automatic logic [55:0] mk_ctrl(input logic [2:0] dest, input logic [2:0] src,
                                           input logic dom, input logic [2:0] ty,
                                           input logic [7:0] op, input logic [31:0] addr,
                                           input logic [1:0] len);
      return {dest, src, 4'hA, dom, ty, op, addr, len};
   endfunction

   function automatic logic [76:0] exp_req(input logic [2:0] src, input logic [2:0] ty,
                                           input logic [7:0] op, input logic [31:0] addr,
                                           input logic [1:0] len, input logic [31:0] d);
      return {ty, src, op[4:0], addr, len, d};
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0; domain = 1'b0; ctrl = '0; data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (out_val !== 1'b0) begin $display("FAIL reset_out_val: got %b want 0", out_val); n_err++; end
      n_cmp++; if (in_rdy !== 1'b1) begin $display("FAIL reset_in_rdy: got %b want 1", in_rdy); n_err++; end
      n_cmp++; if (drop_count !== 8'd0) begin $display("FAIL reset_drop_count: got %0d want 0", drop_count); n_err++; end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_single();
      logic [76:0] want;
      want = {3'd1, 8'h75, 32'h0000_1000, 2'd0, 32'hDEAD_BEEF};
      @(negedge clk);
      out_rdy = 1'b1; in_val = 1'b1; domain = 1'b0;
      ctrl = mk_ctrl(3'd0, 3'd3, 1'b0, 3'd1, 8'h15, 32'h0000_1000, 2'd0);
      data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      in_val = 1'b0;
      n_cmp++; if (out_val !== 1'b1) begin $display("FAIL single_out_val: got %b want 1", out_val); n_err++; end
      n_cmp++; if (out_msg !== want) begin $display("FAIL single_out_msg: got %h want %h", out_msg, want); n_err++; end
      n_cmp++; if (drop_count !== 8'd0) begin $display("FAIL single_drop_count: got %0d want 0", drop_count); n_err++; end
      @(posedge clk); #1;
      n_cmp++; if (out_val !== 1'b0) begin $display("FAIL single_drained: got %b want 0", out_val); n_err++; end
   endtask

   task automatic test_backpressure();
      logic [76:0] want [3];
      for (int i = 0; i < 3; i++)
         want[i] = exp_req(3'(i + 1), 3'd0, 8'(8'h20 + i), 32'(32'h4000 + 4 * i), 2'd0, 32'(32'hA000 + i));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_rdy = 1'b0; in_val = 1'b1;
         ctrl = mk_ctrl(3'd0, 3'(i + 1), 1'b0, 3'd0, 8'(8'h20 + i), 32'(32'h4000 + 4 * i), 2'd0);
         data = 32'(32'hA000 + i);
         #1;
         n_cmp++;
         if (in_rdy !== (i < 2)) begin $display("FAIL bp_in_rdy_%0d: got %b want %b", i, in_rdy, (i < 2)); n_err++; end
         @(posedge clk);
      end
      #1;
      n_cmp++; if (out_msg !== want[0]) begin $display("FAIL bp_stall_head: got %h want %h", out_msg, want[0]); n_err++; end
      @(negedge clk);
      out_rdy = 1'b1;
      #1;
      n_cmp++; if (in_rdy !== 1'b1) begin $display("FAIL bp_release_in_rdy: got %b want 1", in_rdy); n_err++; end
      @(posedge clk); #1;
      in_val = 1'b0;
      n_cmp++; if (out_msg !== want[1]) begin $display("FAIL bp_order_1: got %h want %h", out_msg, want[1]); n_err++; end
      @(posedge clk); #1;
      n_cmp++; if (out_val !== 1'b1 || out_msg !== want[2]) begin $display("FAIL bp_order_2: got %b/%h want 1/%h", out_val, out_msg, want[2]); n_err++; end
      @(posedge clk); #1;
      n_cmp++; if (out_val !== 1'b0) begin $display("FAIL bp_drained: got %b want 0", out_val); n_err++; end
   endtask

   task automatic test_drop();
      @(negedge clk);
      out_rdy = 1'b1; in_val = 1'b1;
      ctrl = mk_ctrl(3'd1, 3'd2, 1'b0, 3'd0, 8'h00, 32'h0, 2'd0);
      #1;
      n_cmp++; if (in_rdy !== 1'b1) begin $display("FAIL drop_in_rdy: got %b want 1", in_rdy); n_err++; end
      @(posedge clk); #1;
      n_cmp++; if (out_val !== 1'b0) begin $display("FAIL drop_out_val: got %b want 0", out_val); n_err++; end
      n_cmp++; if (drop_count !== 8'd1) begin $display("FAIL drop_count_1: got %0d want 1", drop_count); n_err++; end
      repeat (299) @(posedge clk);
      #1;
      in_val = 1'b0;
      n_cmp++; if (drop_count !== 8'd255) begin $display("FAIL drop_count_sat: got %0d want 255", drop_count); n_err++; end
      n_cmp++; if (out_val !== 1'b0) begin $display("FAIL drop_out_val_end: got %b want 0", out_val); n_err++; end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         out_rdy = 1'b0; in_val = 1'b1;
         ctrl = mk_ctrl(3'd0, 3'd5, 1'b1, 3'd1, 8'(8'h30 + i), 32'(32'h5000 + 4 * i), 2'd0);
         data = 32'(32'hB000 + i);
         @(posedge clk);
      end
      @(negedge clk);
      in_val = 1'b0; reset = 1'b1; out_rdy = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (out_val !== 1'b0) begin $display("FAIL rstmid_out_val: got %b want 0", out_val); n_err++; end
      n_cmp++; if (in_rdy !== 1'b1) begin $display("FAIL rstmid_in_rdy: got %b want 1", in_rdy); n_err++; end
      n_cmp++; if (drop_count !== 8'd0) begin $display("FAIL rstmid_drop_count: got %0d want 0", drop_count); n_err++; end
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (out_val !== 1'b0) begin $display("FAIL rstmid_no_emit_%0d: got %b want 0", i, out_val); n_err++; end
      end
   endtask

   task automatic test_back_to_back();
      logic [55:0] ctrl_a [10];
      logic [31:0] data_a [10];
      logic [76:0] want   [10];
      int in_idx = 0;
      int out_idx = 0;
      for (int i = 0; i < 10; i++) begin
         ctrl_a[i] = mk_ctrl(3'd0, 3'(i), 1'b0, 3'd0, 8'(8'h40 + 3 * i), 32'(32'h2000 + 4 * i), 2'd0);
         data_a[i] = 32'(32'hC0DE_0000 + i);
         want[i]   = exp_req(3'(i), 3'd0, 8'(8'h40 + 3 * i), 32'(32'h2000 + 4 * i), 2'd0, data_a[i]);
      end
      for (int cyc = 0; cyc < 40 && out_idx < 10; cyc++) begin
         @(negedge clk);
         out_rdy = (cyc >= 2);
         in_val  = (in_idx < 10);
         if (in_idx < 10) begin ctrl = ctrl_a[in_idx]; data = data_a[in_idx]; end
         #1;
         if (cyc >= 2 && in_idx < 10) begin
            n_cmp++;
            if (in_rdy !== 1'b1 || out_val !== 1'b1) begin
               $display("FAIL b2b_full_flow_%0d: got rdy=%b val=%b want 1/1", cyc, in_rdy, out_val); n_err++;
            end
         end
         if (out_val && out_rdy) begin
            n_cmp++;
            if (out_msg !== want[out_idx]) begin
               $display("FAIL b2b_order_%0d: got %h want %h", out_idx, out_msg, want[out_idx]); n_err++;
            end
            out_idx++;
         end
         if (in_val && in_rdy) in_idx++;
      end
      in_val = 1'b0;
      n_cmp++; if (out_idx != 10) begin $display("FAIL b2b_count: got %0d want 10", out_idx); n_err++; end
      @(posedge clk); #1;
      n_cmp++; if (out_val !== 1'b0) begin $display("FAIL b2b_drained: got %b want 0", out_val); n_err++; end
   endtask

   task automatic test_domain();
      logic [76:0] want;
      logic        dom;
      for (int k = 0; k < 4; k++) begin
         dom = (k % 2 == 0);
         want = exp_req(3'd1, 3'd0, 8'(8'h10 + k), 32'(32'h3000 + 4 * k), 2'd0, 32'(32'hD000 + k));
         @(negedge clk);
         out_rdy = 1'b1; in_val = 1'b1; domain = dom;
         ctrl = mk_ctrl(3'd0, 3'd1, dom, 3'd0, 8'(8'h10 + k), 32'(32'h3000 + 4 * k), 2'd0);
         data = 32'(32'hD000 + k);
         @(posedge clk); #1;
         n_cmp++;
         if (out_val !== 1'b1 || out_req_domain !== dom || out_msg !== want) begin
            $display("FAIL domain_%0d: got val=%b dom=%b msg=%h want 1/%b/%h", k, out_val, out_req_domain, out_msg, dom, want);
            n_err++;
         end
      end
      in_val = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_drop();
      test_reset_mid();
      test_back_to_back();
      test_domain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/plab5_mcore_net_msg_to_mem_req_q.md
# plab5_mcore_net_msg_to_mem_req_q

Bank-side terminating adapter for the memory-request network. It accepts split control/data network messages addressed to one cache/memory bank and strips the network header. It re-packs the fields into a standard memory request whose opaque high bits carry the originating core id, and buffers up to two requests in a 2-entry queue ahead of the bank. Misrouted messages are discarded and counted.

## Interface
- p_bank_id, 0: network destination index of this bank.
- p_mem_opaque_nbits (mo), 8; p_mem_addr_nbits (ma), 32; p_mem_data_nbits (md), 32.
- p_net_opaque_nbits (no), 4; p_net_srcdest_nbits (ns), 3.
- Derived: npc = VC_MEM_REQ_MSG_NBITS(mo,ma,md) - md (45); cnb = (npc+1) + no + 2*ns (56).
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock.
  - reset  in  1  synchronous active-high reset.
- Input side:
  - domain  in  1  {L} security domain of the bank side.
  - in_val  in  1  network message valid.
  - in_rdy  out  1  adapter can accept.
  - in_msg_control  in  cnb  {Control domain}: {dest, src, opaque, payload}, MSB first; payload = {req_domain, type(3), opaque(mo), addr(ma), len(2)}.
  - in_msg_data  in  md  {Domain domain} write data.
- Output side:
  - out_val  out  1  memory request valid.
  - out_rdy  in  1  bank accepts.
  - out_msg  out  VC_MEM_REQ_MSG_NBITS(mo,ma,md)  {type, opaque, addr, len, data}.
  - out_req_domain  out  1  req_domain bit of the head entry.
- Status:
  - drop_count  out  8  saturating count of discarded messages.

## Operation
- Decode is combinational from input fields.
- Accept condition: in_val && in_rdy.
  - If dest == p_bank_id: enqueue {req_domain, packed request}.
  - If dest != p_bank_id: consume the message (in_rdy already high), do not enqueue, increment drop_count; it saturates at 255.
- Repack rules:
  - type, addr, len and data are copied unchanged.
  - Output opaque = {src[ns-1:0], payload_opaque[mo-ns-1:0]}. The source field overwrites the opaque top ns bits, so the response path can route back to the core.
  - Network opaque is ignored.
- Queue:
  - 2 entries, circular, with 1-bit enq_ptr, deq_ptr and a 2-bit count.
  - in_rdy = (count != 2), or (count == 2 && out_rdy). Same-cycle dequeue frees a slot.
  - out_val = (count != 0). out_msg and out_req_domain come from the deq_ptr entry, registered with no combinational path from input to output.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- A dropped message during a dequeue: only the dequeue takes effect.
- Pointers wrap modulo 2.

## Timing
- Latency is 1 cycle: a request accepted at edge N drives out_val high after edge N when the queue was empty.
- No bypass.
- Throughput is 1 message/cycle sustained when out_rdy is held high.
- Reset values: count=0, pointers=0, drop_count=0, out_val=0, in_rdy=1.
  - Queue storage is not reset. out_msg is don't-care while out_val=0.
- Reset mid-operation discards all queued entries on the reset edge, and nothing is dequeued on that edge.
- out_val/out_msg remain stable while out_val && !out_rdy (val/rdy rule: no retraction).
- The input side must not depend on in_rdy to raise in_val; the adapter never depends on out_val to raise in_rdy.

## Structure
- Use the existing vc-net-msgs and memreq field macros (DEST/SRC/OPAQUE/PAYLOAD; TYPE/OPAQUE/ADDR/LEN/DATA). No new shared package is needed. Add a single macro for the payload domain-bit position (bit npc) to vc-net-msgs.
- Sub-module: plab5_mcore_NetMsgUnpack, a combinational field splitter for dest, src, req_domain and repacked request.
- The queue is written inline. Its storage is labeled {Domain domain} for data and {Control domain} for control.

## Test plan
- Empty queue, out_rdy=1. Send dest=0 (p_bank_id=0), src=3, opaque=0x15, addr=0x1000, type=write, data=0xDEADBEEF. Required: out_val the next cycle, opaque=0x75, addr/data unchanged, drop_count=0.
- Hold out_rdy=0 and send 3 valid messages. Required: in_rdy falls after 2 are accepted. Release out_rdy: FIFO order is preserved, and the 3rd is accepted in the same cycle as the first dequeue.
- Send dest=1 to p_bank_id=0. Required: consumed in one cycle, out_val stays 0, drop_count goes 0→1. Send 300 such messages: drop_count=255.
- Queue full and in_val=1 with out_rdy=1 every cycle. Required: one enqueue and one dequeue per cycle, count stays 2, 10 messages emerge in order.
- Assert reset with 2 entries queued. Required: out_val=0 and in_rdy=1 the next cycle, drop_count=0, no queued entry is ever emitted.
- Send req_domain=1 with domain=1. Required: out_req_domain=1 with the matching entry, and it toggles correctly across alternating domains.
